// File: rtl/spi_slave.sv
// spi_slave
//   SPI target for the peripheral side of the four-wire link. SCLK, SS_n and
//   MOSI are oversampled in the P_CLK domain through 2-FF synchronisers. MOSI
//   is deserialised into bytes and a one-deep transmit holding register is
//   serialised onto MISO, LSB first. All four SPI modes are supported, and
//   frames may carry several bytes while SS_n stays low.
//   SCLK high and low phases must each last at least 4 P_CLK cycles
//   (OVERSAMPLE_MIN), so that every pin edge is seen by the edge detectors.
//
// Ports
//   P_CLK        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   i_SCLK       SPI clock from the master (asynchronous)
//   i_SS_n       slave select, active low (asynchronous)
//   i_MOSI       serial data from the master (asynchronous)
//   o_MISO       serial data to the master, high impedance when not selected
//   i_SPI_MODE   {CPOL, CPHA}, latched at frame start
//   i_TX_DATA    next byte to return to the master
//   i_TX_VALID   i_TX_DATA valid; loads when o_TX_READY is also high
//   o_TX_READY   holding register empty
//   o_RX_DATA    last complete received byte
//   o_RX_VALID   one-cycle pulse when o_RX_DATA updates
//   o_UNDERRUN   one-cycle pulse when a byte starts with the holding register empty
//   o_FRAME_ERR  one-cycle pulse when SS_n deasserts mid-byte
//   o_BUSY       high while selected
module spi_slave (
  input  logic       P_CLK,
  input  logic       reset_n,
  input  logic       i_SCLK,
  input  logic       i_SS_n,
  input  logic       i_MOSI,
  output logic       o_MISO,
  input  logic [1:0] i_SPI_MODE,
  input  logic [7:0] i_TX_DATA,
  input  logic       i_TX_VALID,
  output logic       o_TX_READY,
  output logic [7:0] o_RX_DATA,
  output logic       o_RX_VALID,
  output logic       o_UNDERRUN,
  output logic       o_FRAME_ERR,
  output logic       o_BUSY
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // Synchroniser and edge-detect registers
  logic       sclk_meta_r, sclk_sync_r, sclk_prev_r;
  logic       ss_meta_r, ss_sync_r, ss_prev_r;
  logic       mosi_meta_r, mosi_sync_r;

  // Frame state and datapath
  logic [0:0] state_r;
  logic       cpol_r, cpha_r;
  logic [2:0] bit_cnt_r;
  logic [6:0] rx_shift_r;   // bit 7 is taken straight from MOSI on completion
  logic [7:0] tx_shift_r;
  logic       miso_r;
  logic [7:0] hold_r;
  logic       tx_ready_r;
  logic [7:0] rx_data_r;
  logic       rx_valid_r, underrun_r, frame_err_r;

  // Decoded events
  logic       sclk_rise_s, sclk_fall_s, ss_fall_s, ss_rise_s;
  logic       lead_s, trail_s, in_frame_s;
  logic       start_s, sample_s, shift_s, byte_done_s;
  logic       consume_s, load_s;
  logic [7:0] next_tx_s;

  // Edge detection, mode-dependent edge roles and holding-register handshake
  always_comb begin
    sclk_rise_s = sclk_sync_r & ~sclk_prev_r;
    sclk_fall_s = ~sclk_sync_r & sclk_prev_r;
    ss_fall_s   = ~ss_sync_r & ss_prev_r;
    ss_rise_s   = ss_sync_r & ~ss_prev_r;

    // Leading edge moves SCLK away from its idle level
    if (cpol_r) begin
      lead_s  = sclk_fall_s;
      trail_s = sclk_rise_s;
    end else begin
      lead_s  = sclk_rise_s;
      trail_s = sclk_fall_s;
    end

    // SCLK activity is ignored in IDLE and in the cycle the frame closes
    in_frame_s = (state_r == ST_ACTIVE) & ~ss_rise_s;
    start_s    = (state_r == ST_IDLE) & ss_fall_s;

    if (cpha_r) begin
      sample_s = in_frame_s & trail_s;
      shift_s  = in_frame_s & lead_s;
    end else begin
      sample_s = in_frame_s & lead_s;
      shift_s  = in_frame_s & trail_s;
    end

    byte_done_s = sample_s & (bit_cnt_r == 3'd7);
    consume_s   = start_s | byte_done_s;
    load_s      = i_TX_VALID & tx_ready_r;
    // An empty holding register returns zeros; a same-cycle load is not
    // visible to the consume and is kept for the next boundary
    next_tx_s   = tx_ready_r ? 8'h00 : hold_r;
  end

  // Two-flop synchronisers plus a third stage on SCLK and SS_n for edge detection
  always_ff @(posedge P_CLK or negedge reset_n) begin
    if (!reset_n) begin
      sclk_meta_r <= 1'b0;
      sclk_sync_r <= 1'b0;
      sclk_prev_r <= 1'b0;
      ss_meta_r   <= 1'b1;
      ss_sync_r   <= 1'b1;
      ss_prev_r   <= 1'b1;
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
    end else begin
      sclk_meta_r <= i_SCLK;
      sclk_sync_r <= sclk_meta_r;
      sclk_prev_r <= sclk_sync_r;
      ss_meta_r   <= i_SS_n;
      ss_sync_r   <= ss_meta_r;
      ss_prev_r   <= ss_sync_r;
      mosi_meta_r <= i_MOSI;
      mosi_sync_r <= mosi_meta_r;
    end
  end

  // Frame state machine
  always_ff @(posedge P_CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:   state_r <= ss_fall_s ? ST_ACTIVE : ST_IDLE;
        ST_ACTIVE: state_r <= ss_rise_s ? ST_IDLE : ST_ACTIVE;
        default:   state_r <= ST_IDLE;
      endcase
    end
  end

  // Shift datapath: mode latch, bit counter, rx assembly and MISO drive
  always_ff @(posedge P_CLK or negedge reset_n) begin
    if (!reset_n) begin
      cpol_r     <= 1'b0;
      cpha_r     <= 1'b0;
      bit_cnt_r  <= 3'd0;
      rx_shift_r <= 7'd0;
      tx_shift_r <= 8'h00;
      miso_r     <= 1'b0;
    end else if (start_s) begin
      cpol_r     <= i_SPI_MODE[1];
      cpha_r     <= i_SPI_MODE[0];
      bit_cnt_r  <= 3'd0;
      rx_shift_r <= 7'd0;
      tx_shift_r <= next_tx_s;
      // First bit is presented at once; with cpha=1 the first leading
      // edge re-drives the same bit
      miso_r     <= next_tx_s[0];
    end else begin
      if (sample_s) begin
        if (bit_cnt_r != 3'd7) begin
          rx_shift_r[bit_cnt_r] <= mosi_sync_r;
        end
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end
      // Reload on completion so the next byte follows with no gap
      if (byte_done_s) begin
        tx_shift_r <= next_tx_s;
      end
      // bit_cnt_r already counts the bits sampled, so it indexes the next bit out
      if (shift_s) begin
        miso_r <= tx_shift_r[bit_cnt_r];
      end
    end
  end

  // Received byte register and status pulses
  always_ff @(posedge P_CLK or negedge reset_n) begin
    if (!reset_n) begin
      rx_data_r   <= 8'h00;
      rx_valid_r  <= 1'b0;
      underrun_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      if (byte_done_s) begin
        rx_data_r <= {mosi_sync_r, rx_shift_r};
      end
      rx_valid_r  <= byte_done_s;
      underrun_r  <= consume_s & tx_ready_r;
      frame_err_r <= (state_r == ST_ACTIVE) & ss_rise_s & (bit_cnt_r != 3'd0);
    end
  end

  // One-deep transmit holding register
  always_ff @(posedge P_CLK or negedge reset_n) begin
    if (!reset_n) begin
      hold_r     <= 8'h00;
      tx_ready_r <= 1'b1;
    end else begin
      if (load_s) begin
        hold_r <= i_TX_DATA;
      end
      if (load_s) begin
        tx_ready_r <= 1'b0;
      end else if (consume_s) begin
        tx_ready_r <= 1'b1;
      end
    end
  end

  assign o_MISO      = (state_r == ST_ACTIVE) ? miso_r : 1'bz;
  assign o_TX_READY  = tx_ready_r;
  assign o_RX_DATA   = rx_data_r;
  assign o_RX_VALID  = rx_valid_r;
  assign o_UNDERRUN  = underrun_r;
  assign o_FRAME_ERR = frame_err_r;
  assign o_BUSY      = (state_r == ST_ACTIVE);

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI target (slave) for the peripheral side of the four-wire link: the counterpart to our SPI master. All SPI pins are oversampled in the P_CLK domain. The block deserialises MOSI into bytes and serialises a one-deep transmit holding register onto MISO, LSB first, in any of the four SPI modes. It supports multi-byte frames while SS_n stays low.

## Interface
- OVERSAMPLE_MIN, 4: minimum SCLK half-period in P_CLK cycles. Documentation-only; checked by the bench assertion.
- P_CLK  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_SCLK  in  1  SPI clock from master (asynchronous).
- i_SS_n  in  1  slave select, active low (asynchronous).
- i_MOSI  in  1  serial data from master (asynchronous).
- o_MISO  out  1  serial data to master; 1'bZ when not selected.
- i_SPI_MODE  in  2  {CPOL, CPHA}. Sampled at frame start only.
- i_TX_DATA  in  8  next byte to return to master.
- i_TX_VALID  in  1  i_TX_DATA valid.
- o_TX_READY  out  1  holding register empty; load occurs when i_TX_VALID & o_TX_READY.
- o_RX_DATA  out  8  last complete received byte. Held until the next byte completes.
- o_RX_VALID  out  1  one-cycle pulse when o_RX_DATA updates.
- o_UNDERRUN  out  1  one-cycle pulse when a byte starts with the holding register empty.
- o_FRAME_ERR  out  1  one-cycle pulse when SS_n deasserts mid-byte.
- o_BUSY  out  1  high while selected (synchronised SS_n low).

## Operation
- Input synchronisation:
  - i_SCLK, i_SS_n and i_MOSI each pass through a 2-FF synchroniser.
  - A third register on SCLK and SS_n gives edge detection.
  - Leading edge = the SCLK transition away from CPOL; trailing edge = the transition back to CPOL.
- State machine:
  - IDLE -> ACTIVE on synchronised SS_n falling.
  - ACTIVE -> IDLE on synchronised SS_n rising.
- Entering ACTIVE:
  - Latch {cpol, cpha} from i_SPI_MODE.
  - Clear bit counter (3 bits) and rx shift register.
  - Load tx shift register from the holding register and set o_TX_READY.
  - If the holding register is empty, load 8'h00 and pulse o_UNDERRUN.
- Sampling MOSI: on the leading edge when cpha=0, on the trailing edge when cpha=1.
  - The sampled bit goes to rx_shift[bit_cnt]; bit_cnt increments.
- Driving MISO:
  - cpha=0: drive tx_shift[0] on the ACTIVE entry cycle; advance to the next bit on each trailing edge.
  - cpha=1: advance to the next bit on each leading edge, first bit on the first leading edge.
  - o_MISO holds between edges.
- Byte completion (8th sample, bit_cnt wraps 7->0):
  - o_RX_DATA <= assembled byte; pulse o_RX_VALID.
  - Reload tx shift register from holding, or 8'h00 with o_UNDERRUN pulse, so back-to-back bytes need no gap.
- Mid-byte SS_n rise (bit_cnt != 0):
  - Discard the partial byte; no o_RX_VALID; pulse o_FRAME_ERR.
  - A non-empty holding register stays loaded.
- SCLK edges while IDLE are ignored. i_MOSI is ignored outside sample edges.
- i_SPI_MODE changes during ACTIVE have no effect until the next frame.
- Holding register:
  - Writable any time o_TX_READY=1, including while ACTIVE.
  - The byte is consumed only at a byte boundary.
- Reset values:
  - o_MISO=Z, o_TX_READY=1, o_RX_DATA=8'h00.
  - o_RX_VALID, o_UNDERRUN, o_FRAME_ERR, o_BUSY = 0.
  - State IDLE; synchroniser registers reset to SS_n=1, SCLK=0.
- reset_n asserted mid-frame: immediate return to reset values; holding register cleared.

## Timing
- Pin-to-edge-detect latency: 3 P_CLK cycles. SCLK high and low phases must each be ≥ 4 P_CLK, matching the master at CLOCK_DIVIDER=8.
- o_MISO timing:
  - Changes 1 cycle after the internal edge detect, or 1 cycle after ACTIVE entry for the first cpha=0 bit.
  - Worst case 4 P_CLK after the causing pin event.
- o_RX_VALID: asserted the cycle after the 8th sample edge is detected.
- o_TX_READY: rises the cycle after the holding register is consumed; falls the cycle after a load.
- If a load and a consume occur in the same cycle, the consume takes the old contents and the new byte is stored; o_TX_READY stays 0.
- o_BUSY follows synchronised SS_n, 3 P_CLK after the pin.
- A new frame may start 1 cycle after ACTIVE -> IDLE. SS_n high pulse ≥ 4 P_CLK.

## Test plan
- Mode 0 single byte:
  - Stimulus: preload 0xA5, master sends 0x3C (LSB first, half-period 4).
  - Required: o_RX_DATA=0x3C with one o_RX_VALID pulse; master receives 0xA5; o_MISO=Z after SS_n high.
- All modes:
  - Stimulus: repeat the single-byte case for modes 1, 2, 3 with tx 0x96, rx 0x5A.
  - Required: exact match in every mode; no o_FRAME_ERR.
- Multi-byte frame:
  - Stimulus: SS_n low for 3 bytes (0x01, 0x02, 0x03); refill holding after each o_TX_READY (0x11, 0x22, 0x33).
  - Required: three o_RX_VALID pulses in order; master reads 0x11, 0x22, 0x33.
- Underrun:
  - Stimulus: start a frame with no preload.
  - Required: o_UNDERRUN pulse at SS_n fall; master reads 0x00; rx still correct.
- Abort:
  - Stimulus: raise SS_n after 5 SCLK cycles.
  - Required: o_FRAME_ERR pulse; no o_RX_VALID; o_RX_DATA unchanged; next full frame correct.
- Reset mid-frame:
  - Stimulus: assert reset_n low during bit 3.
  - Required: all outputs at reset values immediately (o_MISO=Z, o_TX_READY=1); a later frame completes normally.
